// File: rtl/fpnew_pkg.sv
// Shared FPU types used by the in-order completion buffer.
//   status_t    : IEEE exception flags {NV,DZ,OF,UF,NX}, MSB first.
//   rob_state_e : lifecycle of one completion-buffer slot.
// The slot record itself (state/result/status/tag) depends on the
// Width/TagWidth parameters, so it is declared inside fpnew_rob.
package fpnew_pkg;

  typedef struct packed {
    logic nv;  // invalid operation
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

  typedef enum logic [1:0] {
    ROB_FREE    = 2'd0,
    ROB_PENDING = 2'd1,
    ROB_DONE    = 2'd2
  } rob_state_e;

endpackage

// File: rtl/fpnew_rob_if.sv
// Bundle of the three handshakes around the completion buffer:
//   alloc_* : issue stage requests a slot and receives its ID.
//   wb_*    : NumPorts writeback ports deliver results by slot ID.
//   out_*   : in-order retire stream with result, status and tag.
// Signal suffixes are seen from the buffer: _i enters it, _o leaves it.
// Modports: slave = the buffer, master = issue/writeback/consumer side.
interface fpnew_rob_if #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned NumPorts = 5,
  parameter int unsigned TagWidth = 5
);
  localparam int unsigned IdWidth = $clog2(Depth);

  logic                        alloc_valid_i;
  logic                        alloc_ready_o;
  logic [TagWidth-1:0]         alloc_tag_i;
  logic [IdWidth-1:0]          alloc_id_o;

  logic [NumPorts-1:0]         wb_valid_i;
  logic [NumPorts*IdWidth-1:0] wb_id_i;
  logic [NumPorts*Width-1:0]   wb_result_i;
  logic [NumPorts*5-1:0]       wb_status_i;
  logic [NumPorts-1:0]         wb_ready_o;

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [Width-1:0]            result_o;
  logic [4:0]                  status_o;
  logic [TagWidth-1:0]         tag_o;

  modport slave (
    input  alloc_valid_i, alloc_tag_i, wb_valid_i, wb_id_i, wb_result_i,
           wb_status_i, out_ready_i,
    output alloc_ready_o, alloc_id_o, wb_ready_o, out_valid_o, result_o,
           status_o, tag_o
  );

  modport master (
    output alloc_valid_i, alloc_tag_i, wb_valid_i, wb_id_i, wb_result_i,
           wb_status_i, out_ready_i,
    input  alloc_ready_o, alloc_id_o, wb_ready_o, out_valid_o, result_o,
           status_o, tag_o
  );

endinterface

// File: rtl/fpnew_rob_wb_sel.sv
// Writeback selector for one completion-buffer slot (SlotIdx).
// Scans all writeback ports and picks the lowest-index port whose
// wb_id matches this slot.
//   wb_valid_i/wb_id_i/wb_result_i/wb_status_i : flattened port buses
//   hit_o    : some port targets this slot this cycle
//   result_o : winning port's result (0 when no hit)
//   status_o : winning port's status (0 when no hit)
module fpnew_rob_wb_sel #(
  parameter int unsigned Width    = 32,
  parameter int unsigned NumPorts = 5,
  parameter int unsigned IdWidth  = 2,
  parameter int unsigned SlotIdx  = 0
) (
  input  logic [NumPorts-1:0]         wb_valid_i,
  input  logic [NumPorts*IdWidth-1:0] wb_id_i,
  input  logic [NumPorts*Width-1:0]   wb_result_i,
  input  logic [NumPorts*5-1:0]       wb_status_i,
  output logic                        hit_o,
  output logic [Width-1:0]            result_o,
  output logic [4:0]                  status_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // one unassigned and no latch is inferred.
    hit_o    = 1'b0;
    result_o = '0;
    status_o = '0;
    // Walk from the highest port down so the lowest matching index is the
    // last assignment and therefore wins.
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (wb_valid_i[p] && (wb_id_i[p*IdWidth +: IdWidth] == IdWidth'(SlotIdx))) begin
        hit_o    = 1'b1;
        result_o = wb_result_i[p*Width +: Width];
        status_o = wb_status_i[p*5 +: 5];
      end
    end
  end

endmodule

// File: rtl/fpnew_rob.sv
// In-order completion buffer between FPU issue and result output.
// Slots are allocated at the tail in issue order, filled out of order by
// NumPorts writeback ports, and retired from the head strictly in order.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   rob           : alloc / writeback / retire handshakes (slave side)
//   flush_i       : drop every slot, return pointers to 0 (keeps fflags)
//   fflags_clr_i  : clear the sticky exception flags
//   fflags_o      : sticky OR of all retired status
//   count_o       : occupied slots, busy_o = count_o != 0
module fpnew_rob
  import fpnew_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned NumPorts = 5,
  parameter int unsigned TagWidth = 5,
  localparam int unsigned IdWidth = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fpnew_rob_if.slave       rob,
  input  logic             flush_i,
  input  logic             fflags_clr_i,
  output status_t          fflags_o,
  output logic [IdWidth:0] count_o,
  output logic             busy_o
);

  typedef struct packed {
    rob_state_e          state;
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } rob_entry_t;

  rob_entry_t         entry_q [Depth];
  rob_entry_t         entry_d [Depth];
  logic [IdWidth-1:0] head_q, head_d, tail_q, tail_d;
  logic [IdWidth:0]   count_q, count_d;
  status_t            fflags_q, fflags_d;

  logic [Depth-1:0]   wb_hit;
  logic [Width-1:0]   wb_sel_result [Depth];
  logic [4:0]         wb_sel_status [Depth];
  logic [IdWidth-1:0] wb_id [NumPorts];

  logic alloc_fire, retire_fire;

  for (genvar s = 0; s < Depth; s++) begin : g_wb_sel
    fpnew_rob_wb_sel #(
      .Width   (Width),
      .NumPorts(NumPorts),
      .IdWidth (IdWidth),
      .SlotIdx (s)
    ) u_wb_sel (
      .wb_valid_i (rob.wb_valid_i),
      .wb_id_i    (rob.wb_id_i),
      .wb_result_i(rob.wb_result_i),
      .wb_status_i(rob.wb_status_i),
      .hit_o      (wb_hit[s]),
      .result_o   (wb_sel_result[s]),
      .status_o   (wb_sel_status[s])
    );
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) wb_id[p] = rob.wb_id_i[p*IdWidth +: IdWidth];
  end

  // A slot freed by retire this cycle is not offered to alloc until the
  // next cycle, because readiness looks only at the registered count.
  assign rob.alloc_ready_o = !rst_i && !flush_i && (count_q < (IdWidth+1)'(Depth));
  assign rob.alloc_id_o    = tail_q;
  assign rob.wb_ready_o    = {NumPorts{!rst_i}};
  assign rob.out_valid_o   = !rst_i && (entry_q[head_q].state == ROB_DONE);
  assign rob.result_o      = entry_q[head_q].result;
  assign rob.status_o      = entry_q[head_q].status;
  assign rob.tag_o         = entry_q[head_q].tag;
  assign fflags_o          = fflags_q;
  assign count_o           = count_q;
  assign busy_o            = (count_q != '0);

  assign alloc_fire  = rob.alloc_valid_i && rob.alloc_ready_o;
  assign retire_fire = rob.out_valid_o && rob.out_ready_i && !flush_i;

  always_comb begin
    entry_d  = entry_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    fflags_d = fflags_q;

    if (flush_i) begin
      for (int s = 0; s < Depth; s++) entry_d[s].state = ROB_FREE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Only a PENDING slot accepts a result; FREE/DONE targets are dropped,
      // which also keeps a stalled head stable.
      for (int s = 0; s < Depth; s++) begin
        if (wb_hit[s] && (entry_q[s].state == ROB_PENDING)) begin
          entry_d[s].state  = ROB_DONE;
          entry_d[s].result = wb_sel_result[s];
          entry_d[s].status = wb_sel_status[s];
        end
      end
      if (retire_fire) begin
        entry_d[head_q].state = ROB_FREE;
        head_d                = head_q + IdWidth'(1);
      end
      if (alloc_fire) begin
        entry_d[tail_q].state = ROB_PENDING;
        entry_d[tail_q].tag   = rob.alloc_tag_i;
        tail_d                = tail_q + IdWidth'(1);
      end
      count_d = count_q + (IdWidth+1)'(alloc_fire) - (IdWidth+1)'(retire_fire);
    end

    // Clear has priority over accumulation, but a retire in the same cycle
    // still lands its own status in the fresh flags.
    if (fflags_clr_i) begin
      fflags_d = retire_fire ? entry_q[head_q].status : '0;
    end else if (retire_fire) begin
      fflags_d = fflags_q | entry_q[head_q].status;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the slot array is reset as well, since result_o/status_o/tag_o
      // are read straight from the head slot and must be 0 after reset.
      for (int s = 0; s < Depth; s++) entry_q[s] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop takes the pre-edge
      // value of its _d regardless of statement order.
      entry_q  <= entry_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // Writebacks must target a slot that is waiting for its result.
  for (genvar p = 0; p < NumPorts; p++) begin : g_wb_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      (rob.wb_valid_i[p] && !flush_i) |-> (entry_q[wb_id[p]].state == ROB_PENDING));
    // Two ports aiming at one slot in the same cycle is a producer bug.
    for (genvar q = p + 1; q < NumPorts; q++) begin : g_dup_chk
      assert property (@(posedge clk_i) disable iff (rst_i)
        !(rob.wb_valid_i[p] && rob.wb_valid_i[q] && !flush_i && (wb_id[p] == wb_id[q])));
    end
  end

endmodule

// File: tb/tb_fpnew_rob.sv
// Directed bench for fpnew_rob with Depth=4, NumPorts=2.
module tb_fpnew_rob;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int NP = 2;
  localparam int TW = 5;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          fflags_clr_i;
  logic [4:0]    fflags_o;
  logic [IW:0]   count_o;
  logic          busy_o;

  int passed = 0;
  int total  = 0;

  fpnew_rob_if #(.Width(W), .Depth(D), .NumPorts(NP), .TagWidth(TW)) rob_if ();

  fpnew_rob #(.Width(W), .Depth(D), .NumPorts(NP), .TagWidth(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rob         (rob_if),
    .flush_i     (flush_i),
    .fflags_clr_i(fflags_clr_i),
    .fflags_o    (fflags_o),
    .count_o     (count_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob_if.alloc_valid_i = 1'b0;
    rob_if.alloc_tag_i   = '0;
    rob_if.wb_valid_i    = '0;
    rob_if.wb_id_i       = '0;
    rob_if.wb_result_i   = '0;
    rob_if.wb_status_i   = '0;
    rob_if.out_ready_i   = 1'b0;
    flush_i              = 1'b0;
    fflags_clr_i         = 1'b0;
  endtask

  task automatic restart();
    idle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic do_alloc(input logic [TW-1:0] tag);
    rob_if.alloc_valid_i = 1'b1;
    rob_if.alloc_tag_i   = tag;
    cycle();
    rob_if.alloc_valid_i = 1'b0;
  endtask

  task automatic set_wb(input int port, input logic [IW-1:0] id,
                        input logic [W-1:0] res, input logic [4:0] st);
    rob_if.wb_valid_i[port]            = 1'b1;
    rob_if.wb_id_i[port*IW +: IW]      = id;
    rob_if.wb_result_i[port*W +: W]    = res;
    rob_if.wb_status_i[port*5 +: 5]    = st;
  endtask

  task automatic wb_one(input int port, input logic [IW-1:0] id,
                        input logic [W-1:0] res, input logic [4:0] st);
    set_wb(port, id, res, st);
    cycle();
    rob_if.wb_valid_i = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    cycle();
    cycle();
    total++; if (rob_if.alloc_ready_o !== 1'b0) $display("FAIL rst_alloc_ready: got %b expected 0", rob_if.alloc_ready_o); else passed++;
    total++; if (rob_if.wb_ready_o !== 2'b00) $display("FAIL rst_wb_ready: got %b expected 00", rob_if.wb_ready_o); else passed++;
    rst_i = 1'b0;
    #1;
    total++; if (count_o !== 3'd0) $display("FAIL rst_count: got %0d expected 0", count_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_o); else passed++;
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", rob_if.out_valid_o); else passed++;
    total++; if (fflags_o !== 5'b0) $display("FAIL rst_fflags: got %b expected 00000", fflags_o); else passed++;
    total++; if (rob_if.result_o !== 32'h0) $display("FAIL rst_result: got %h expected 0", rob_if.result_o); else passed++;
    total++; if (rob_if.tag_o !== 5'd0) $display("FAIL rst_tag: got %0d expected 0", rob_if.tag_o); else passed++;
    total++; if (rob_if.alloc_id_o !== 2'd0) $display("FAIL rst_alloc_id: got %0d expected 0", rob_if.alloc_id_o); else passed++;
    total++; if (rob_if.alloc_ready_o !== 1'b1) $display("FAIL post_rst_alloc_ready: got %b expected 1", rob_if.alloc_ready_o); else passed++;
    total++; if (rob_if.wb_ready_o !== 2'b11) $display("FAIL post_rst_wb_ready: got %b expected 11", rob_if.wb_ready_o); else passed++;
  endtask

  task automatic test_in_order();
    restart();
    rob_if.alloc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rob_if.alloc_tag_i = TW'(i + 1);
      total++; if (rob_if.alloc_id_o !== IW'(i)) $display("FAIL io_alloc_id%0d: got %0d expected %0d", i, rob_if.alloc_id_o, i); else passed++;
      cycle();
    end
    rob_if.alloc_valid_i = 1'b0;
    total++; if (count_o !== 3'd3) $display("FAIL io_count3: got %0d expected 3", count_o); else passed++;
    wb_one(0, 2'd2, 32'h4000_0000, 5'b0);
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL io_valid_after_id2: got %b expected 0", rob_if.out_valid_o); else passed++;
    wb_one(1, 2'd1, 32'h3F80_0000, 5'b0);
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL io_valid_after_id1: got %b expected 0", rob_if.out_valid_o); else passed++;
    wb_one(0, 2'd0, 32'h1234_5678, 5'b0);
    rob_if.out_ready_i = 1'b1;
    total++; if (rob_if.out_valid_o !== 1'b1) $display("FAIL io_valid_r0: got %b expected 1", rob_if.out_valid_o); else passed++;
    total++; if (rob_if.tag_o !== 5'd1) $display("FAIL io_tag_r0: got %0d expected 1", rob_if.tag_o); else passed++;
    total++; if (rob_if.result_o !== 32'h1234_5678) $display("FAIL io_result_r0: got %h expected 12345678", rob_if.result_o); else passed++;
    cycle();
    total++; if (rob_if.out_valid_o !== 1'b1) $display("FAIL io_valid_r1: got %b expected 1", rob_if.out_valid_o); else passed++;
    total++; if (rob_if.tag_o !== 5'd2) $display("FAIL io_tag_r1: got %0d expected 2", rob_if.tag_o); else passed++;
    total++; if (rob_if.result_o !== 32'h3F80_0000) $display("FAIL io_result_r1: got %h expected 3f800000", rob_if.result_o); else passed++;
    cycle();
    total++; if (rob_if.tag_o !== 5'd3) $display("FAIL io_tag_r2: got %0d expected 3", rob_if.tag_o); else passed++;
    total++; if (rob_if.result_o !== 32'h4000_0000) $display("FAIL io_result_r2: got %h expected 40000000", rob_if.result_o); else passed++;
    cycle();
    rob_if.out_ready_i = 1'b0;
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL io_valid_empty: got %b expected 0", rob_if.out_valid_o); else passed++;
    total++; if (count_o !== 3'd0) $display("FAIL io_count0: got %0d expected 0", count_o); else passed++;
  endtask

  task automatic test_full_wrap();
    restart();
    rob_if.alloc_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rob_if.alloc_tag_i = TW'(i + 4);
      total++; if (rob_if.alloc_id_o !== IW'(i)) $display("FAIL fw_alloc_id%0d: got %0d expected %0d", i, rob_if.alloc_id_o, i); else passed++;
      cycle();
    end
    rob_if.alloc_valid_i = 1'b0;
    total++; if (count_o !== 3'd4) $display("FAIL fw_count_full: got %0d expected 4", count_o); else passed++;
    total++; if (rob_if.alloc_ready_o !== 1'b0) $display("FAIL fw_ready_full: got %b expected 0", rob_if.alloc_ready_o); else passed++;
    wb_one(0, 2'd0, 32'h0000_0A0A, 5'b0);
    // Retire while full with alloc requested: the freed slot is not reused this cycle.
    rob_if.alloc_valid_i = 1'b1;
    rob_if.alloc_tag_i   = 5'd8;
    rob_if.out_ready_i   = 1'b1;
    total++; if (rob_if.alloc_ready_o !== 1'b0) $display("FAIL fw_ready_full_retire: got %b expected 0", rob_if.alloc_ready_o); else passed++;
    total++; if (rob_if.out_valid_o !== 1'b1) $display("FAIL fw_head_valid: got %b expected 1", rob_if.out_valid_o); else passed++;
    cycle();
    rob_if.out_ready_i = 1'b0;
    total++; if (count_o !== 3'd3) $display("FAIL fw_count_after_retire: got %0d expected 3", count_o); else passed++;
    total++; if (rob_if.alloc_id_o !== 2'd0) $display("FAIL fw_wrap_id: got %0d expected 0", rob_if.alloc_id_o); else passed++;
    cycle();
    rob_if.alloc_valid_i = 1'b0;
    total++; if (count_o !== 3'd4) $display("FAIL fw_count_refill: got %0d expected 4", count_o); else passed++;
    // Slots 1,2,3,0 hold tags 5,6,7,8; retire tag 5, then alloc+retire together.
    wb_one(0, 2'd1, 32'h11, 5'b0);
    rob_if.out_ready_i = 1'b1;
    cycle();
    rob_if.out_ready_i = 1'b0;
    wb_one(1, 2'd2, 32'h22, 5'b0);
    rob_if.alloc_valid_i = 1'b1;
    rob_if.alloc_tag_i   = 5'd9;
    rob_if.out_ready_i   = 1'b1;
    total++; if (rob_if.alloc_id_o !== 2'd1) $display("FAIL fw_both_alloc_id: got %0d expected 1", rob_if.alloc_id_o); else passed++;
    total++; if (rob_if.tag_o !== 5'd6) $display("FAIL fw_both_head_tag: got %0d expected 6", rob_if.tag_o); else passed++;
    cycle();
    rob_if.alloc_valid_i = 1'b0;
    rob_if.out_ready_i   = 1'b0;
    total++; if (count_o !== 3'd3) $display("FAIL fw_count_both: got %0d expected 3", count_o); else passed++;
  endtask

  task automatic test_multi_port();
    logic [W-1:0] exp_res [4];
    exp_res = '{32'h0000_0010, 32'hAAAA_0001, 32'h0000_0012, 32'hBBBB_0003};
    restart();
    for (int i = 0; i < 4; i++) do_alloc(TW'(10 + i));
    set_wb(0, 2'd1, 32'hAAAA_0001, 5'b0);
    set_wb(1, 2'd3, 32'hBBBB_0003, 5'b0);
    cycle();
    rob_if.wb_valid_i = '0;
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL mp_head_pending: got %b expected 0", rob_if.out_valid_o); else passed++;
    set_wb(0, 2'd0, 32'h0000_0010, 5'b0);
    set_wb(1, 2'd2, 32'h0000_0012, 5'b0);
    cycle();
    rob_if.wb_valid_i  = '0;
    rob_if.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (rob_if.out_valid_o !== 1'b1) $display("FAIL mp_valid%0d: got %b expected 1", i, rob_if.out_valid_o); else passed++;
      total++; if (rob_if.tag_o !== TW'(10 + i)) $display("FAIL mp_tag%0d: got %0d expected %0d", i, rob_if.tag_o, 10 + i); else passed++;
      total++; if (rob_if.result_o !== exp_res[i]) $display("FAIL mp_result%0d: got %h expected %h", i, rob_if.result_o, exp_res[i]); else passed++;
      cycle();
    end
    rob_if.out_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) $display("FAIL mp_count0: got %0d expected 0", count_o); else passed++;
  endtask

  task automatic test_fflags();
    restart();
    for (int i = 0; i < 3; i++) do_alloc(TW'(i + 1));
    set_wb(0, 2'd0, 32'h1, 5'b00001);
    set_wb(1, 2'd1, 32'h2, 5'b10000);
    cycle();
    rob_if.wb_valid_i = '0;
    wb_one(0, 2'd2, 32'h3, 5'b00100);
    rob_if.out_ready_i = 1'b1;
    total++; if (rob_if.status_o !== 5'b00001) $display("FAIL ff_status0: got %b expected 00001", rob_if.status_o); else passed++;
    cycle();
    total++; if (fflags_o !== 5'b00001) $display("FAIL ff_acc1: got %b expected 00001", fflags_o); else passed++;
    total++; if (rob_if.status_o !== 5'b10000) $display("FAIL ff_status1: got %b expected 10000", rob_if.status_o); else passed++;
    cycle();
    total++; if (fflags_o !== 5'b10001) $display("FAIL ff_acc2: got %b expected 10001", fflags_o); else passed++;
    fflags_clr_i = 1'b1;
    cycle();
    rob_if.out_ready_i = 1'b0;
    total++; if (fflags_o !== 5'b00100) $display("FAIL ff_clr_retire: got %b expected 00100", fflags_o); else passed++;
    cycle();
    fflags_clr_i = 1'b0;
    total++; if (fflags_o !== 5'b00000) $display("FAIL ff_clr_alone: got %b expected 00000", fflags_o); else passed++;
  endtask

  task automatic test_flush();
    restart();
    do_alloc(5'd20);
    wb_one(0, 2'd0, 32'h20, 5'b01000);
    rob_if.out_ready_i = 1'b1;
    cycle();
    rob_if.out_ready_i = 1'b0;
    total++; if (fflags_o !== 5'b01000) $display("FAIL fl_pre_fflags: got %b expected 01000", fflags_o); else passed++;
    for (int i = 0; i < 3; i++) do_alloc(TW'(21 + i));
    total++; if (count_o !== 3'd3) $display("FAIL fl_count3: got %0d expected 3", count_o); else passed++;
    flush_i = 1'b1;
    set_wb(0, 2'd1, 32'hFFFF_FFFF, 5'b00001);
    rob_if.out_ready_i = 1'b1;
    #1;
    total++; if (rob_if.alloc_ready_o !== 1'b0) $display("FAIL fl_ready_during: got %b expected 0", rob_if.alloc_ready_o); else passed++;
    cycle();
    flush_i            = 1'b0;
    rob_if.wb_valid_i  = '0;
    rob_if.out_ready_i = 1'b0;
    total++; if (count_o !== 3'd0) $display("FAIL fl_count0: got %0d expected 0", count_o); else passed++;
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL fl_out_valid: got %b expected 0", rob_if.out_valid_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL fl_busy: got %b expected 0", busy_o); else passed++;
    total++; if (fflags_o !== 5'b01000) $display("FAIL fl_fflags_kept: got %b expected 01000", fflags_o); else passed++;
    total++; if (rob_if.alloc_id_o !== 2'd0) $display("FAIL fl_alloc_id: got %0d expected 0", rob_if.alloc_id_o); else passed++;
    do_alloc(5'd25);
    total++; if (count_o !== 3'd1) $display("FAIL fl_count_realloc: got %0d expected 1", count_o); else passed++;
  endtask

  task automatic test_stall_reset();
    restart();
    do_alloc(5'd30);
    do_alloc(5'd31);
    wb_one(0, 2'd0, 32'h1, 5'b00010);
    rob_if.out_ready_i = 1'b1;
    cycle();
    rob_if.out_ready_i = 1'b0;
    total++; if (fflags_o !== 5'b00010) $display("FAIL sr_pre_fflags: got %b expected 00010", fflags_o); else passed++;
    wb_one(1, 2'd1, 32'hDEAD_BEEF, 5'b00100);
    for (int i = 0; i < 5; i++) begin
      total++; if (rob_if.out_valid_o !== 1'b1) $display("FAIL sr_valid%0d: got %b expected 1", i, rob_if.out_valid_o); else passed++;
      total++; if (rob_if.result_o !== 32'hDEAD_BEEF) $display("FAIL sr_result%0d: got %h expected deadbeef", i, rob_if.result_o); else passed++;
      total++; if (rob_if.tag_o !== 5'd31) $display("FAIL sr_tag%0d: got %0d expected 31", i, rob_if.tag_o); else passed++;
      cycle();
    end
    rst_i = 1'b1;
    #1;
    total++; if (rob_if.alloc_ready_o !== 1'b0) $display("FAIL sr_rst_alloc_ready: got %b expected 0", rob_if.alloc_ready_o); else passed++;
    total++; if (rob_if.wb_ready_o !== 2'b00) $display("FAIL sr_rst_wb_ready: got %b expected 00", rob_if.wb_ready_o); else passed++;
    cycle();
    rst_i = 1'b0;
    #1;
    total++; if (rob_if.out_valid_o !== 1'b0) $display("FAIL sr_out_valid: got %b expected 0", rob_if.out_valid_o); else passed++;
    total++; if (rob_if.result_o !== 32'h0) $display("FAIL sr_result: got %h expected 0", rob_if.result_o); else passed++;
    total++; if (rob_if.tag_o !== 5'd0) $display("FAIL sr_tag: got %0d expected 0", rob_if.tag_o); else passed++;
    total++; if (rob_if.status_o !== 5'b0) $display("FAIL sr_status: got %b expected 00000", rob_if.status_o); else passed++;
    total++; if (count_o !== 3'd0) $display("FAIL sr_count: got %0d expected 0", count_o); else passed++;
    total++; if (fflags_o !== 5'b0) $display("FAIL sr_fflags: got %b expected 00000", fflags_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_multi_port();
    test_fflags();
    test_flush();
    test_stall_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
